reg_file_wb: RTL and testbench

//  8x8 CPU register file; the operand source and result sink on the other side of the ALU.
//  - Two read ports drive the ALU DATA1/DATA2 inputs.
//  - Write port A takes the ALU RESULT.
//  - Write port B takes load data returned by the data-memory/cache path.
//  - A one-entry load scoreboard raises HAZARD so the control unit stalls on use of a pending load.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 71 +++++++
 rtl/reg_file_wb.sv | 99 +++++++++
 tb/tb_reg_file_wb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register file and its load scoreboard.
// Optional feature macro used by the register-file files: REGFILE_BYPASS_EN.
package cpu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    // Sized from the address width so every address maps to a real register.
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Register-address comparator shared by the hazard and forwarding logic.
    function automatic logic addr_match(input reg_addr_t a, input reg_addr_t b);
        return (a == b);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// One-entry load scoreboard: tracks the single outstanding load destination
// and flags reads or writes that would race it.
// Optional feature macro: REGFILE_BYPASS_EN (returning load data is forwarded,
// so read matches stop stalling during the return cycle).
import cpu_pkg::*;

module reg_scoreboard (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      busywait,
    input  logic      load_pend,
    input  logic      load_valid,
    input  logic      we,
    input  reg_addr_t in_addr,
    input  reg_addr_t rd1_addr,
    input  reg_addr_t rd2_addr,
    output reg_addr_t pend_addr,
    output logic      retire,
    output logic      hazard
);

    logic      pend_valid_r;
    reg_addr_t pend_addr_r;
    logic      retire_s;
    logic      issue_s;
    logic      rd_hit_s;
    logic      hazard_s;

    // A return frees the slot in the same edge, so a new load may issue back-to-back.
    assign retire_s = load_valid & pend_valid_r;
    assign issue_s  = load_pend & ~busywait & (~pend_valid_r | retire_s);

    // Pending-load state: issue has priority because a retiring load is already done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= {REG_ADDR_W{1'b0}};
        end else if (issue_s) begin
            pend_valid_r <= 1'b1;
            pend_addr_r  <= in_addr;
        end else if (retire_s) begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= pend_addr_r;
        end else begin
            pend_valid_r <= pend_valid_r;
            pend_addr_r  <= pend_addr_r;
        end
    end

    // Hazard: any use of the pending destination, or a second load attempt.
    always_comb begin
        rd_hit_s = addr_match(rd1_addr, pend_addr_r) | addr_match(rd2_addr, pend_addr_r);
`ifdef REGFILE_BYPASS_EN
        if (load_valid) begin
            rd_hit_s = 1'b0;
        end else begin
            rd_hit_s = addr_match(rd1_addr, pend_addr_r) | addr_match(rd2_addr, pend_addr_r);
        end
`endif
        if (pend_valid_r) begin
            hazard_s = rd_hit_s | (we & addr_match(in_addr, pend_addr_r)) | load_pend;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign pend_addr = pend_addr_r;
    assign retire    = retire_s;
    assign hazard    = hazard_s;

endmodule

// File: rtl/reg_file_wb.sv
// 8x8 CPU register file with an ALU write port, a load-return write port and
// a one-entry load scoreboard that raises HAZARD for the control unit.
// Optional feature macro: REGFILE_BYPASS_EN (read ports forward same-edge
// write data; load data takes priority over ALU data).
import cpu_pkg::*;

module reg_file_wb (
    input  logic      CLK,
    input  logic      RESET,
    input  data_t     IN,
    input  reg_addr_t INADDRESS,
    input  logic      WRITEENABLE,
    input  logic      BUSYWAIT,
    input  logic      LOAD_PEND,
    input  logic      LOAD_VALID,
    input  data_t     LOAD_DATA,
    input  reg_addr_t OUT1ADDRESS,
    input  reg_addr_t OUT2ADDRESS,
    output data_t     OUT1,
    output data_t     OUT2,
    output logic      HAZARD
);

    data_t     regs_r [NUM_REGS];
    logic      alu_commit_s;
    logic      retire_s;
    reg_addr_t pend_addr_s;
    data_t     rd1_s;
    data_t     rd2_s;

    // A load issue occupies the write-address bus, so it blocks the ALU write.
    assign alu_commit_s = WRITEENABLE & ~BUSYWAIT & ~LOAD_PEND;

    reg_scoreboard u_scoreboard (
        .clk        (CLK),
        .rst_n      (RESET),
        .busywait   (BUSYWAIT),
        .load_pend  (LOAD_PEND),
        .load_valid (LOAD_VALID),
        .we         (WRITEENABLE),
        .in_addr    (INADDRESS),
        .rd1_addr   (OUT1ADDRESS),
        .rd2_addr   (OUT2ADDRESS),
        .pend_addr  (pend_addr_s),
        .retire     (retire_s),
        .hazard     (HAZARD)
    );

    // Register array: the ALU write is the younger instruction and wins a same-register tie.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (alu_commit_s && addr_match(INADDRESS, reg_addr_t'(i))) begin
                    regs_r[i] <= IN;
                end else if (retire_s && addr_match(pend_addr_s, reg_addr_t'(i))) begin
                    regs_r[i] <= LOAD_DATA;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Read port 1: committed contents, optionally forwarding this edge's write data.
    always_comb begin
        rd1_s = regs_r[OUT1ADDRESS];
`ifdef REGFILE_BYPASS_EN
        if (retire_s && addr_match(OUT1ADDRESS, pend_addr_s)) begin
            rd1_s = LOAD_DATA;
        end else if (alu_commit_s && addr_match(OUT1ADDRESS, INADDRESS)) begin
            rd1_s = IN;
        end else begin
            rd1_s = regs_r[OUT1ADDRESS];
        end
`endif
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd2_s = regs_r[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
        if (retire_s && addr_match(OUT2ADDRESS, pend_addr_s)) begin
            rd2_s = LOAD_DATA;
        end else if (alu_commit_s && addr_match(OUT2ADDRESS, INADDRESS)) begin
            rd2_s = IN;
        end else begin
            rd2_s = regs_r[OUT2ADDRESS];
        end
`endif
    end

    assign OUT1 = rd1_s;
    assign OUT2 = rd2_s;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_reg_file_wb;

    logic       CLK;
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITEENABLE;
    logic       BUSYWAIT;
    logic       LOAD_PEND;
    logic       LOAD_VALID;
    logic [7:0] LOAD_DATA;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;
    logic       HAZARD;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [7:0] m_regs [8];
    logic       m_pv;
    logic [2:0] m_pa;

    reg_file_wb dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN          (IN),
        .INADDRESS   (INADDRESS),
        .WRITEENABLE (WRITEENABLE),
        .BUSYWAIT    (BUSYWAIT),
        .LOAD_PEND   (LOAD_PEND),
        .LOAD_VALID  (LOAD_VALID),
        .LOAD_DATA   (LOAD_DATA),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2),
        .HAZARD      (HAZARD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_pv = 1'b0;
        m_pa = 3'd0;
    endtask

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (LOAD_VALID && m_pv && a == m_pa) return LOAD_DATA;
        if (WRITEENABLE && !BUSYWAIT && !LOAD_PEND && a == INADDRESS) return IN;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_hz();
        logic rh;
        rh = (OUT1ADDRESS == m_pa) || (OUT2ADDRESS == m_pa);
`ifdef REGFILE_BYPASS_EN
        rh = rh && !LOAD_VALID;
`endif
        return m_pv && (rh || (WRITEENABLE && INADDRESS == m_pa) || LOAD_PEND);
    endfunction

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        logic ret, iss, alu;
        ret = LOAD_VALID && m_pv;
        iss = LOAD_PEND && !BUSYWAIT && (!m_pv || ret);
        alu = WRITEENABLE && !BUSYWAIT && !LOAD_PEND;
        if (ret) begin
            m_regs[m_pa] = LOAD_DATA;
            m_pv = 1'b0;
        end
        if (alu) m_regs[INADDRESS] = IN;
        if (iss) begin
            m_pv = 1'b1;
            m_pa = INADDRESS;
        end
    endtask

    task automatic clear_inputs();
        IN = 8'h00; INADDRESS = 3'd0; WRITEENABLE = 1'b0; BUSYWAIT = 1'b0;
        LOAD_PEND = 1'b0; LOAD_VALID = 1'b0; LOAD_DATA = 8'h00;
        OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    endtask

    // Called at a negedge with inputs set: compare outputs, advance one edge.
    task automatic step();
        #2;
        chk("out1", OUT1, exp_rd(OUT1ADDRESS));
        chk("out2", OUT2, exp_rd(OUT2ADDRESS));
        chk("hazard", {7'd0, HAZARD}, {7'd0, exp_hz()});
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    initial begin
        clear_inputs();
        model_clear();
        RESET = 1'b0;
        #1;
        chk("reset_out1", OUT1, 8'h00);
        chk("reset_hazard", {7'd0, HAZARD}, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;

        // ALU write to r3
        WRITEENABLE = 1'b1; INADDRESS = 3'd3; IN = 8'h2A;
        step();
        clear_inputs();
        OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd4;
        #1;
        chk("wr_r3", OUT1, 8'h2A);
        chk("wr_r4_untouched", OUT2, 8'h00);

        // BUSYWAIT freezes ALU write and load issue
        BUSYWAIT = 1'b1; WRITEENABLE = 1'b1; INADDRESS = 3'd4; IN = 8'h55; LOAD_PEND = 1'b1;
        step();
        clear_inputs();
        OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd4;
        #1;
        chk("busy_r4", OUT1, 8'h00);
        chk("busy_no_issue", {7'd0, HAZARD}, 8'h00);

        // load to r5: hazard then return
        LOAD_PEND = 1'b1; INADDRESS = 3'd5;
        step();
        clear_inputs();
        OUT2ADDRESS = 3'd5;
        #1;
        chk("load_hazard", {7'd0, HAZARD}, 8'h01);
        LOAD_VALID = 1'b1; LOAD_DATA = 8'hF0;
        step();
        clear_inputs();
        OUT2ADDRESS = 3'd5;
        #1;
        chk("load_ret_r5", OUT2, 8'hF0);
        chk("load_ret_hz", {7'd0, HAZARD}, 8'h00);

        // ALU write r2 and load return r5 in the same edge
        LOAD_PEND = 1'b1; INADDRESS = 3'd5;
        step();
        clear_inputs();
        WRITEENABLE = 1'b1; INADDRESS = 3'd2; IN = 8'h11; LOAD_VALID = 1'b1; LOAD_DATA = 8'h22;
        step();
        clear_inputs();
        OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd5;
        #1;
        chk("dual_r2", OUT1, 8'h11);
        chk("dual_r5", OUT2, 8'h22);

        // same register: ALU write wins over load return
        LOAD_PEND = 1'b1; INADDRESS = 3'd1;
        step();
        clear_inputs();
        WRITEENABLE = 1'b1; INADDRESS = 3'd1; IN = 8'hAA; LOAD_VALID = 1'b1; LOAD_DATA = 8'h55;
        step();
        clear_inputs();
        OUT1ADDRESS = 3'd1;
        #1;
        chk("same_reg_alu_wins", OUT1, 8'hAA);

        // one-cycle turnaround: return r7 and issue r0 in the same edge
        LOAD_PEND = 1'b1; INADDRESS = 3'd7;
        step();
        clear_inputs();
        LOAD_VALID = 1'b1; LOAD_DATA = 8'h3C; LOAD_PEND = 1'b1; INADDRESS = 3'd0;
        step();
        clear_inputs();
        OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd0;
        #1;
        chk("turn_r7", OUT1, 8'h3C);
        chk("turn_hz_r0", {7'd0, HAZARD}, 8'h01);
        LOAD_VALID = 1'b1; LOAD_DATA = 8'h99;
        step();
        clear_inputs();

        // read of r6 while its ALU write is pending at the next edge
        WRITEENABLE = 1'b1; INADDRESS = 3'd6; IN = 8'h7E; OUT1ADDRESS = 3'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_r6", OUT1, 8'h7E);
`else
        chk("nobypass_r6", OUT1, 8'h00);
`endif
        step();
        clear_inputs();

        // async reset mid-run with a load pending
        LOAD_PEND = 1'b1; INADDRESS = 3'd2;
        step();
        clear_inputs();
        OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd3;
        #2;
        RESET = 1'b0;
        #1;
        model_clear();
        chk("arst_out1", OUT1, 8'h00);
        chk("arst_out2", OUT2, 8'h00);
        chk("arst_hazard", {7'd0, HAZARD}, 8'h00);
        LOAD_VALID = 1'b1; LOAD_DATA = 8'hFF;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        step();
        clear_inputs();
        OUT1ADDRESS = 3'd2;
        #1;
        chk("dropped_load", OUT1, 8'h00);

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            WRITEENABLE = 1'($urandom_range(0, 1));
            INADDRESS   = 3'($urandom_range(0, 7));
            IN          = 8'($urandom_range(0, 255));
            BUSYWAIT    = ($urandom_range(0, 3) == 0);
            LOAD_PEND   = ($urandom_range(0, 4) == 0);
            LOAD_VALID  = ($urandom_range(0, 2) == 0);
            LOAD_DATA   = 8'($urandom_range(0, 255));
            OUT1ADDRESS = 3'($urandom_range(0, 7));
            OUT2ADDRESS = 3'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
